// File: rtl/wb_host_master_if.sv
// Command/response stream plus Wishbone classic bus of wb_host_master.
// master: the initiator side; slave: upstream test logic together with the Wishbone target.
interface wb_host_master_if;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic        cmd_we_i;
    logic [31:0] cmd_adr_i;
    logic [31:0] cmd_dat_i;
    logic [3:0]  cmd_sel_i;

    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_dat_o;
    logic        rsp_err_o;

    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic        wbm_ack_i;
    logic [31:0] wbm_dat_i;

    modport master (
        input  cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
        output cmd_ready_o,
        output rsp_valid_o, rsp_dat_o, rsp_err_o,
        input  rsp_ready_i,
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        input  wbm_ack_i, wbm_dat_i
    );

    modport slave (
        output cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
        input  cmd_ready_o,
        input  rsp_valid_o, rsp_dat_o, rsp_err_o,
        output rsp_ready_i,
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        output wbm_ack_i, wbm_dat_i
    );
endinterface

// File: rtl/wb_host_master.sv
// Wishbone classic initiator turning single commands into one bus transfer each.
// Define WBM_TIMEOUT_EN to add a watchdog that aborts a transfer after TIMEOUT_CYCLES without ack.
module wb_host_master #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    wb_host_master_if.master     bus,
    output logic                 busy_o
);

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        RESP
    } state_t;

    state_t      state_q, state_d;
    logic        cyc_q, stb_q, we_q;
    logic [3:0]  sel_q;
    logic [31:0] adr_q, dat_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_dat_q;
    logic        accept, acked, timeout, rsp_done;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > (2 ** CNT_W) - 1) begin : g_bad_timeout
        $error("wb_host_master: TIMEOUT_CYCLES out of range for CNT_W");
    end

    assign accept   = (state_q == IDLE) && bus.cmd_valid_i;
    assign acked    = (state_q == BUS) && bus.wbm_ack_i;
    assign rsp_done = (state_q == RESP) && rsp_valid_q && bus.rsp_ready_i;

`ifdef WBM_TIMEOUT_EN
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             rsp_err_q;

    // An ack on the final watchdog cycle takes priority over the abort.
    assign timeout = (state_q == BUS) && !bus.wbm_ack_i && (cnt_q == LAST_CNT);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            cnt_q     <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            if (accept) begin
                cnt_q <= '0;
            end else if ((state_q == BUS) && !bus.wbm_ack_i) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (acked) begin
                rsp_err_q <= 1'b0;
            end else if (timeout) begin
                rsp_err_q <= 1'b1;
            end
        end
    end

    assign bus.rsp_err_o = rsp_err_q;
`else
    assign timeout       = 1'b0;
    assign bus.rsp_err_o = 1'b0;
`endif

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.cmd_valid_i) state_d = BUS;
            BUS:     if (bus.wbm_ack_i || timeout) state_d = RESP;
            RESP:    if (bus.rsp_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Bus and response registers; adr/dat are left stale after a transfer.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            adr_q       <= '0;
            dat_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
        end else if (accept) begin
            cyc_q <= 1'b1;
            stb_q <= 1'b1;
            we_q  <= bus.cmd_we_i;
            sel_q <= bus.cmd_sel_i;
            adr_q <= bus.cmd_adr_i;
            dat_q <= bus.cmd_dat_i;
        end else if (acked || timeout) begin
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            rsp_valid_q <= 1'b1;
            rsp_dat_q   <= (acked && !we_q) ? bus.wbm_dat_i : 32'h0;
        end else if (rsp_done) begin
            rsp_valid_q <= 1'b0;
        end
    end

    assign bus.cmd_ready_o = (state_q == IDLE);
    assign bus.rsp_valid_o = rsp_valid_q;
    assign bus.rsp_dat_o   = rsp_dat_q;
    assign bus.wbm_cyc_o   = cyc_q;
    assign bus.wbm_stb_o   = stb_q;
    assign bus.wbm_we_o    = we_q;
    assign bus.wbm_sel_o   = sel_q;
    assign bus.wbm_adr_o   = adr_q;
    assign bus.wbm_dat_o   = dat_q;
    assign busy_o          = (state_q != IDLE);

endmodule
